// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared FSM type and constants for spi_slave
// SYNC_DEPTH is 2 when SPI_SLAVE_SYNC2_EN is defined, otherwise 1.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } spi_state_t;

  localparam int DATA_WIDTH_DEFAULT = 8;

`ifdef SPI_SLAVE_SYNC2_EN
  localparam int SYNC_DEPTH = 2;
`else
  localparam int SYNC_DEPTH = 1;
`endif

endpackage

// File: rtl/spi_sync_edge.sv
// rtl/spi_sync_edge.sv - input synchronizer with rise/fall detection against a one-cycle-delayed copy
// Depth comes from spi_pkg::SYNC_DEPTH (set by SPI_SLAVE_SYNC2_EN).
module spi_sync_edge
  import spi_pkg::*;
#(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic sync_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_DEPTH-1:0] sync_q;
  logic                  prev_q;
  logic [SYNC_DEPTH:0]   prime_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync_q  <= {SYNC_DEPTH{RESET_VAL}};
      prev_q  <= RESET_VAL;
      prime_q <= '0;
    end else begin
      sync_q[0] <= d_i;
      for (int i = 1; i < SYNC_DEPTH; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      prev_q  <= sync_q[SYNC_DEPTH-1];
      prime_q <= {prime_q[SYNC_DEPTH-1:0], 1'b1};
    end
  end

  // Edges stay masked until the chain and its delayed copy hold real samples,
  // so a line already asserted at reset release is not seen as an edge.
  assign sync_o = sync_q[SYNC_DEPTH-1];
  assign rise_o = prime_q[SYNC_DEPTH] & sync_o & ~prev_q;
  assign fall_o = prime_q[SYNC_DEPTH] & ~sync_o & prev_q;

endmodule

// File: rtl/spi_slave.sv
// rtl/spi_slave.sv - SPI mode-0 slave, one word per DATA_WIDTH SCLK rises, back-to-back words per CS frame
// SPI_SLAVE_SYNC2_EN selects two-flop input synchronizers (edge latency 3 clk instead of 2).
module spi_slave
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH    = DATA_WIDTH_DEFAULT,
  parameter int CLK_RATIO_MIN = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  SCLK,
  input  logic                  CS,
  input  logic                  MOSI,
  output logic                  MISO,
  output logic                  MISO_oe,
  input  logic [DATA_WIDTH-1:0] slaveDataToSend,
  output logic [DATA_WIDTH-1:0] slaveDataReceived,
  output logic                  dataValid,
  output logic                  busy
);

  localparam int               CNT_W    = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);
  // Documents the clk/SCLK ratio the synchronizers assume; no logic depends on it.
  localparam int unused_clk_ratio_min = CLK_RATIO_MIN;

  logic sclk_sync_unused, sclk_rise, sclk_fall;
  logic cs_sync, cs_rise, cs_fall;

  spi_sync_edge #(.RESET_VAL(1'b0)) u_sclk_sync (
    .clk   (clk),
    .reset (reset),
    .d_i   (SCLK),
    .sync_o(sclk_sync_unused),
    .rise_o(sclk_rise),
    .fall_o(sclk_fall)
  );

  spi_sync_edge #(.RESET_VAL(1'b1)) u_cs_sync (
    .clk   (clk),
    .reset (reset),
    .d_i   (CS),
    .sync_o(cs_sync),
    .rise_o(cs_rise),
    .fall_o(cs_fall)
  );

  logic [SYNC_DEPTH-1:0] mosi_q;
  logic                  mosi_s;
  assign mosi_s = mosi_q[SYNC_DEPTH-1];

  spi_state_t            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] tx_q, tx_d;
  logic [DATA_WIDTH-1:0] rx_q, rx_d;
  logic [DATA_WIDTH-1:0] rcv_q, rcv_d;
  logic                  miso_q, miso_d;
  logic                  dv_q, dv_d;
  logic [DATA_WIDTH-1:0] tx_shift, rx_next;

  assign tx_shift = tx_q << 1;
  assign rx_next  = (rx_q << 1) | DATA_WIDTH'(mosi_s);

  always_ff @(posedge clk) begin
    if (!reset) begin
      mosi_q  <= '0;
      state_q <= IDLE;
      cnt_q   <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      rcv_q   <= '0;
      miso_q  <= 1'b0;
      dv_q    <= 1'b0;
    end else begin
      mosi_q[0] <= MOSI;
      for (int i = 1; i < SYNC_DEPTH; i++) begin
        mosi_q[i] <= mosi_q[i-1];
      end
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      rcv_q   <= rcv_d;
      miso_q  <= miso_d;
      dv_q    <= dv_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    rcv_d   = rcv_q;
    miso_d  = miso_q;
    dv_d    = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d  = '0;
        miso_d = 1'b0;
        if (cs_fall) begin
          state_d = SHIFT;
          tx_d    = slaveDataToSend;
          miso_d  = slaveDataToSend[DATA_WIDTH-1];
        end
      end
      SHIFT: begin
        if (cs_rise) begin
          state_d = IDLE;
          cnt_d   = '0;
          rx_d    = '0;
          miso_d  = 1'b0;
        end else begin
          if (sclk_rise) begin
            rx_d = rx_next;
            if (cnt_q == LAST_BIT) begin
              state_d = DONE;
              cnt_d   = '0;
              rcv_d   = rx_next;
              dv_d    = 1'b1;
              tx_d    = slaveDataToSend;
              miso_d  = slaveDataToSend[DATA_WIDTH-1];
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
          // The trailing fall of the previous word lands with cnt 0 and must
          // not shift away the MSB that was just reloaded.
          if (sclk_fall && cnt_q != '0) begin
            tx_d   = tx_shift;
            miso_d = tx_shift[DATA_WIDTH-1];
          end
        end
      end
      DONE: begin
        if (!cs_sync) begin
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
          miso_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        miso_d  = 1'b0;
      end
    endcase
  end

  assign MISO              = miso_q;
  assign MISO_oe           = (state_q != IDLE) & ~cs_sync;
  assign slaveDataReceived = rcv_q;
  assign dataValid         = dv_q;
  assign busy              = (state_q == SHIFT);

endmodule

// File: tb/tb_spi_slave.sv
// tb/tb_spi_slave.sv - randomized self-checking bench for spi_slave against a word-level master/slave model
module tb_spi_slave;

  localparam int W = 8;
`ifdef SPI_SLAVE_SYNC2_EN
  localparam int EXP_LAT = 3;
`else
  localparam int EXP_LAT = 2;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         SCLK = 1'b0;
  logic         CS = 1'b1;
  logic         MOSI = 1'b0;
  logic [W-1:0] slaveDataToSend = '0;
  logic         MISO, MISO_oe, dataValid, busy;
  logic [W-1:0] slaveDataReceived;

  always #10 clk = ~clk;

  spi_slave #(.DATA_WIDTH(W), .CLK_RATIO_MIN(4)) dut (
    .clk              (clk),
    .reset            (reset),
    .SCLK             (SCLK),
    .CS               (CS),
    .MOSI             (MOSI),
    .MISO             (MISO),
    .MISO_oe          (MISO_oe),
    .slaveDataToSend  (slaveDataToSend),
    .slaveDataReceived(slaveDataReceived),
    .dataValid        (dataValid),
    .busy             (busy)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int dv_cnt = 0;
  int dv_cyc = 0;
  int dv_run = 0;
  int dv_run_max = 0;
  int rise_cyc = 0;
  logic [W-1:0] dv_words[$];
  logic [W-1:0] exp_rcv = '0;
  logic [W-1:0] mo_arr[4];
  logic [W-1:0] so_arr[4];

  always @(posedge clk) cyc++;

  // Records every dataValid pulse together with the word it presents.
  always @(posedge clk) begin
    #1;
    if (dataValid) begin
      dv_cnt++;
      dv_cyc = cyc;
      dv_words.push_back(slaveDataReceived);
      dv_run++;
      if (dv_run > dv_run_max) dv_run_max = dv_run;
    end else begin
      dv_run = 0;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clk_wait(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Mode-0 master: MOSI set while SCLK low, MISO sampled at the raw rising edge.
  task automatic xfer(input logic [W-1:0] mo, input logic [W-1:0] next_tx, input int nbits,
                      input bit cs_on_last, output logic [W-1:0] mi);
    mi = '0;
    for (int i = 0; i < nbits; i++) begin
      MOSI = mo[W-1-i];
      clk_wait(4);
      SCLK = 1'b1;
      mi[W-1-i] = MISO;
      if (i == 3) begin
        check_eq("busy_mid_word", 32'(busy), 1);
        check_eq("oe_mid_word", 32'(MISO_oe), 1);
      end
      if (i == W-1) begin
        rise_cyc = cyc;
        slaveDataToSend = next_tx;
        if (cs_on_last) CS = 1'b1;
      end
      clk_wait(4);
      SCLK = 1'b0;
    end
  endtask

  task automatic run_frame(input int nw, input string tag);
    logic [W-1:0] mi;
    int dv_before;
    dv_before = dv_cnt;
    dv_words.delete();
    slaveDataToSend = so_arr[0];
    CS = 1'b0;
    clk_wait(4);
    for (int w = 0; w < nw; w++) begin
      xfer(mo_arr[w], (w + 1 < nw) ? so_arr[w+1] : W'($urandom), W, 1'b0, mi);
      check_eq({tag, "_miso_word"}, 32'(mi), 32'(so_arr[w]));
      exp_rcv = mo_arr[w];
    end
    clk_wait(2);
    CS = 1'b1;
    clk_wait(6);
    check_eq({tag, "_dv_count"}, dv_cnt - dv_before, nw);
    check_eq({tag, "_dv_latency"}, dv_cyc - rise_cyc, EXP_LAT);
    check_eq({tag, "_rcv_hold"}, 32'(slaveDataReceived), 32'(exp_rcv));
    check_eq({tag, "_oe_after"}, 32'(MISO_oe), 0);
    for (int w = 0; w < nw && w < dv_words.size(); w++) begin
      check_eq({tag, "_rx_word"}, 32'(dv_words[w]), 32'(mo_arr[w]));
    end
  endtask

  task automatic check_idle_outputs(input string tag, input logic [W-1:0] rcv);
    check_eq({tag, "_miso"}, 32'(MISO), 0);
    check_eq({tag, "_oe"}, 32'(MISO_oe), 0);
    check_eq({tag, "_busy"}, 32'(busy), 0);
    check_eq({tag, "_dv"}, 32'(dataValid), 0);
    check_eq({tag, "_rcv"}, 32'(slaveDataReceived), 32'(rcv));
  endtask

  initial begin
    logic [W-1:0] mi;
    int dv_before;

    clk_wait(3);
    check_idle_outputs("reset", '0);
    reset = 1'b1;
    clk_wait(4);

    mo_arr[0] = 8'b01010011;
    so_arr[0] = 8'b00001001;
    run_frame(1, "single");

    mo_arr[0] = 8'b00111100;
    mo_arr[1] = 8'b11010111;
    so_arr[0] = 8'b10011000;
    so_arr[1] = 8'b01101010;
    run_frame(2, "b2b");

    dv_before = dv_cnt;
    slaveDataToSend = W'($urandom);
    CS = 1'b0;
    clk_wait(4);
    xfer(W'($urandom), '0, 4, 1'b0, mi);
    CS = 1'b1;
    clk_wait(6);
    check_eq("abort_dv_count", dv_cnt - dv_before, 0);
    check_idle_outputs("abort", exp_rcv);

    dv_before = dv_cnt;
    CS = 1'b0;
    clk_wait(4);
    xfer(W'($urandom), W'($urandom), W, 1'b1, mi);
    clk_wait(6);
    check_eq("cs_race_dv_count", dv_cnt - dv_before, 0);
    check_idle_outputs("cs_race", exp_rcv);

    CS = 1'b0;
    clk_wait(4);
    xfer(W'($urandom), '0, 3, 1'b0, mi);
    reset = 1'b0;
    clk_wait(2);
    exp_rcv = '0;
    check_idle_outputs("rst_held", exp_rcv);
    reset = 1'b1;
    clk_wait(8);
    check_idle_outputs("rst_cs_low", exp_rcv);
    CS = 1'b1;
    clk_wait(6);
    mo_arr[0] = 8'b10111010;
    so_arr[0] = W'($urandom);
    run_frame(1, "after_rst");

    for (int f = 0; f < 8; f++) begin
      int nw;
      nw = $urandom_range(1, 3);
      for (int w = 0; w < nw; w++) begin
        mo_arr[w] = W'($urandom);
        so_arr[w] = W'($urandom);
      end
      run_frame(nw, "rand");
    end

    check_eq("dv_pulse_width", dv_run_max, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/spi_slave.md
SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: bits per transfer.
REQ-002 SHALL have parameter CLK_RATIO_MIN, default 4: minimum clk periods per SCLK period; informational only, with no effect on the RTL.
REQ-003 clk  input  1  system clock; all state changes on the rising edge.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 SCLK  input  1  SPI serial clock from the master (mode 0: CPOL=0, CPHA=0); asynchronous to clk.
REQ-006 CS  input  1  chip select, active-low; this slave's line of the master's CS bus.
REQ-007 MOSI  input  1  serial data from the master, MSB first.
REQ-008 MISO  output  1  serial data to the master, MSB first.
REQ-009 MISO_oe  output  1  high while CS is low (synchronized); low means the external driver releases MISO.
REQ-010 slaveDataToSend  input  DATA_WIDTH  word to transmit; sampled at each byte start.
REQ-011 slaveDataReceived  output  DATA_WIDTH  last complete received word; holds its value until the next completion.
REQ-012 dataValid  output  1  one-clk pulse when slaveDataReceived updates.
REQ-013 busy  output  1  high while a word is in progress.

Function
REQ-014 SCLK, CS and MOSI SHALL pass through the input synchronizer. Edges SHALL be detected by comparing the synchronized value with its one-cycle-delayed copy.
REQ-015 The FSM SHALL have three states: IDLE, SHIFT and DONE.
- IDLE->SHIFT on a CS falling edge.
- SHIFT->DONE on the DATA_WIDTH-th SCLK rising edge.
- DONE->SHIFT after exactly 1 cycle if CS is low; otherwise DONE->IDLE.
REQ-016 On entry to SHIFT from IDLE, the block SHALL load the tx shift register from slaveDataToSend and set MISO to its MSB in the same cycle.
REQ-017 On each synchronized SCLK rising edge in SHIFT, the block SHALL shift MOSI into the LSB of the rx register and increment the bit counter.
REQ-018 On each synchronized SCLK falling edge in SHIFT, the block SHALL shift tx left and drive the next bit on MISO.
REQ-019 In DONE:
- slaveDataReceived SHALL equal the assembled word.
- dataValid SHALL be 1 for exactly this cycle.
- The bit counter SHALL wrap to 0.
- tx SHALL reload from slaveDataToSend, and MISO SHALL show its MSB, so that back-to-back words within one CS frame work.
REQ-020 A CS rising edge in SHIFT SHALL abort the word:
- next state IDLE, counter cleared;
- partial rx discarded, no dataValid;
- slaveDataReceived unchanged.
REQ-021 If a CS rising edge and the final SCLK rising edge are detected in the same cycle, CS SHALL win: abort, no dataValid.
REQ-022 SCLK edges in IDLE SHALL be ignored.
REQ-023 In IDLE, MISO SHALL be 0 and MISO_oe SHALL be 0.
REQ-024 busy SHALL be 1 in SHIFT and 0 in IDLE and DONE.
REQ-025 Latency from a raw SCLK edge to the corresponding internal action SHALL be the synchronizer depth plus 1 clk cycle.
REQ-026 Correct operation SHALL be required only for clk frequency >= CLK_RATIO_MIN x SCLK frequency.

Reset
REQ-027 While reset is low at a clk rising edge, the block SHALL set:
- state to IDLE, counter to 0;
- tx and rx to 0, slaveDataReceived to 0;
- dataValid, busy, MISO and MISO_oe to 0;
- synchronizer flops to SCLK=0, CS=1, MOSI=0.
REQ-028 Reset asserted mid-word SHALL discard the word.
REQ-029 After reset releases with CS already low, the block SHALL stay in IDLE until a new CS falling edge occurs.

Configuration
REQ-030 With SPI_SLAVE_SYNC2_EN defined, each of SCLK, CS and MOSI SHALL use a two-flop synchronizer; edge latency is 3 clk.
REQ-031 Without SPI_SLAVE_SYNC2_EN, each SHALL use a single register stage; edge latency is 2 clk, and CLK_RATIO_MIN is still honoured.

Structure
REQ-032 Shared package spi_pkg SHALL hold the FSM state typedef (IDLE, SHIFT, DONE), the default DATA_WIDTH constant and the synchronizer-depth constant.
REQ-033 One sub-module, spi_sync_edge, SHALL hold the synchronizer plus rise/fall detector. It SHALL be instantiated for SCLK and CS; MOSI uses only its synchronized output.

Verification
REQ-034 Bench SHALL cover all of the following, with clk period 20 and SCLK period 160:
- Single word: CS low, master sends 8'b01010011, slaveDataToSend=8'b00001001 -> slaveDataReceived=8'b01010011, one dataValid pulse, MISO sequence 0,0,0,0,1,0,0,1.
- Back-to-back words in one CS frame: 8'b00111100 then 8'b11010111 from the master, slave sends 8'b10011000 then 8'b01101010 -> two dataValid pulses, both words correct in both directions.
- CS raised after 4 SCLK rising edges -> no dataValid, slaveDataReceived unchanged, busy falls, MISO_oe=0.
- reset low mid-word, then released with CS still low -> all outputs 0; next CS frame with 8'b10111010 received correctly.
- CS rise in the same synchronized cycle as the 8th SCLK rise -> no dataValid.
- Runs with and without SPI_SLAVE_SYNC2_EN, with dataValid timing checked at 3 and 2 clk after the raw final SCLK rise respectively.
